// File: rtl/regfile_sb.sv
// Scoreboarded register file: two read ports with busy flags, two write ports
// (port 1 wins on collision), and an allocation port that marks destinations busy.
module regfile_sb #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned NREG     = 32,
   parameter int unsigned AW       = 5,
   parameter int unsigned REG_READ = 0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [AW-1:0]   rs1,
   input  logic [AW-1:0]   rs2,
   output logic [XLEN-1:0] rdata1,
   output logic [XLEN-1:0] rdata2,
   output logic            busy1,
   output logic            busy2,
   input  logic            we0,
   input  logic [AW-1:0]   wa0,
   input  logic [XLEN-1:0] wd0,
   input  logic            we1,
   input  logic [AW-1:0]   wa1,
   input  logic [XLEN-1:0] wd1,
   input  logic            alloc_en,
   input  logic [AW-1:0]   alloc_rd
);

   logic [XLEN-1:0] r_regs [NREG];
   logic [NREG-1:0] r_busy;

   logic [NREG-1:0] w_wr0;
   logic [NREG-1:0] w_wr1;
   logic [NREG-1:0] w_al;

   logic [XLEN-1:0] w_rd1;
   logic [XLEN-1:0] w_rd2;
   logic            w_bz1;
   logic            w_bz2;

   // One-hot decode; index 0 and addresses >= NREG never decode, so they are ignored.
   always_comb begin
      w_wr0 = '0;
      w_wr1 = '0;
      w_al  = '0;
      for (int unsigned i = 1; i < NREG; i++) begin
         w_wr0[i] = we0      && (wa0      == AW'(i));
         w_wr1[i] = we1      && (wa1      == AW'(i));
         w_al[i]  = alloc_en && (alloc_rd == AW'(i));
      end
   end

   // Register and scoreboard state; a same-cycle alloc beats the clearing write.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            r_regs[i] <= '0;
         end
         r_busy <= '0;
      end else begin
         for (int unsigned i = 1; i < NREG; i++) begin
            if (w_wr1[i]) begin
               r_regs[i] <= wd1;
            end else if (w_wr0[i]) begin
               r_regs[i] <= wd0;
            end
            if (w_al[i]) begin
               r_busy[i] <= 1'b1;
            end else if (w_wr0[i] || w_wr1[i]) begin
               r_busy[i] <= 1'b0;
            end
         end
      end
   end

   // Post-write read view. Registered mode samples the busy bit as it will be
   // after this edge; combinational mode shows current busy minus a pure write.
   always_comb begin
      w_rd1 = '0;
      w_rd2 = '0;
      w_bz1 = 1'b0;
      w_bz2 = 1'b0;
      for (int unsigned i = 0; i < NREG; i++) begin
         if (rs1 == AW'(i)) begin
            w_rd1 = w_wr1[i] ? wd1 : (w_wr0[i] ? wd0 : r_regs[i]);
            w_bz1 = (REG_READ != 0)
                  ? (w_al[i] | (r_busy[i] & ~(w_wr0[i] | w_wr1[i])))
                  : (r_busy[i] & ~((w_wr0[i] | w_wr1[i]) & ~w_al[i]));
         end
         if (rs2 == AW'(i)) begin
            w_rd2 = w_wr1[i] ? wd1 : (w_wr0[i] ? wd0 : r_regs[i]);
            w_bz2 = (REG_READ != 0)
                  ? (w_al[i] | (r_busy[i] & ~(w_wr0[i] | w_wr1[i])))
                  : (r_busy[i] & ~((w_wr0[i] | w_wr1[i]) & ~w_al[i]));
         end
      end
   end

   if (REG_READ != 0) begin : g_reg_read
      logic [XLEN-1:0] r_rdata1;
      logic [XLEN-1:0] r_rdata2;
      logic            r_busy1;
      logic            r_busy2;

      always_ff @(posedge clk) begin
         if (reset) begin
            r_rdata1 <= '0;
            r_rdata2 <= '0;
            r_busy1  <= 1'b0;
            r_busy2  <= 1'b0;
         end else begin
            r_rdata1 <= w_rd1;
            r_rdata2 <= w_rd2;
            r_busy1  <= w_bz1;
            r_busy2  <= w_bz2;
         end
      end

      assign rdata1 = r_rdata1;
      assign rdata2 = r_rdata2;
      assign busy1  = r_busy1;
      assign busy2  = r_busy2;
   end else begin : g_comb_read
      assign rdata1 = w_rd1;
      assign rdata2 = w_rd2;
      assign busy1  = w_bz1;
      assign busy2  = w_bz2;
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a combinational-read instance (32x32) and a registered-read
// instance (16x64) share stimulus and are compared against an array-based model.
module tb_regfile_sb;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [4:0]  rs1, rs2, wa0, wa1, alloc_rd;
   logic        we0, we1, alloc_en;
   logic [63:0] wd0, wd1;

   logic [31:0] a_rd1, a_rd2;
   logic        a_b1, a_b2;
   logic [63:0] b_rd1, b_rd2;
   logic        b_b1, b_b2;

   int checks   = 0;
   int failures = 0;

   // Model state: index 0 = combinational instance, 1 = registered instance.
   logic [63:0] mem [2][32];
   bit          bsy [2][32];

   regfile_sb u_a (
      .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2),
      .rdata1(a_rd1), .rdata2(a_rd2), .busy1(a_b1), .busy2(a_b2),
      .we0(we0), .wa0(wa0), .wd0(wd0[31:0]),
      .we1(we1), .wa1(wa1), .wd1(wd1[31:0]),
      .alloc_en(alloc_en), .alloc_rd(alloc_rd)
   );

   regfile_sb #(.XLEN(64), .NREG(16), .AW(5), .REG_READ(1)) u_b (
      .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2),
      .rdata1(b_rd1), .rdata2(b_rd2), .busy1(b_b1), .busy2(b_b2),
      .we0(we0), .wa0(wa0), .wd0(wd0),
      .we1(we1), .wa1(wa1), .wd1(wd1),
      .alloc_en(alloc_en), .alloc_rd(alloc_rd)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int nreg(input int m);
      return (m == 0) ? 32 : 16;
   endfunction

   function automatic logic [63:0] msk(input int m);
      return (m == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
   endfunction

   function automatic bit ok(input int m, input int a);
      return (a != 0) && (a < nreg(m));
   endfunction

   function automatic bit wrote(input int m, input int a);
      return ok(m, a) && ((we0 && int'(wa0) == a) || (we1 && int'(wa1) == a));
   endfunction

   function automatic bit alloced(input int m, input int a);
      return ok(m, a) && alloc_en && int'(alloc_rd) == a;
   endfunction

   // Value a read of address a sees this cycle, including same-cycle writes.
   function automatic logic [63:0] view(input int m, input int a);
      if (!ok(m, a)) return 64'd0;
      if (we1 && int'(wa1) == a) return wd1 & msk(m);
      if (we0 && int'(wa0) == a) return wd0 & msk(m);
      return mem[m][a];
   endfunction

   function automatic bit busy_now(input int m, input int a);
      return ok(m, a) && bsy[m][a] && !(wrote(m, a) && !alloced(m, a));
   endfunction

   function automatic bit busy_next(input int m, input int a);
      return ok(m, a) && (alloced(m, a) || (bsy[m][a] && !wrote(m, a)));
   endfunction

   task automatic model_edge();
      for (int m = 0; m < 2; m++) begin
         for (int a = 0; a < 32; a++) begin
            if (reset) begin
               mem[m][a] = 64'd0;
               bsy[m][a] = 1'b0;
            end else if (ok(m, a)) begin
               logic [63:0] v;
               bit          bn;
               v  = view(m, a);
               bn = busy_next(m, a);
               mem[m][a] = v;
               bsy[m][a] = bn;
            end
         end
      end
   endtask

   // Inputs are already applied; check combinational outputs, clock once, check registered ones.
   task automatic cycle();
      logic [63:0] e1, e2;
      bit          eb1, eb2;
      #1;
      check("a_rdata1", 64'(a_rd1), view(0, int'(rs1)));
      check("a_rdata2", 64'(a_rd2), view(0, int'(rs2)));
      check("a_busy1",  64'(a_b1),  64'(busy_now(0, int'(rs1))));
      check("a_busy2",  64'(a_b2),  64'(busy_now(0, int'(rs2))));
      e1  = reset ? 64'd0 : view(1, int'(rs1));
      e2  = reset ? 64'd0 : view(1, int'(rs2));
      eb1 = reset ? 1'b0  : busy_next(1, int'(rs1));
      eb2 = reset ? 1'b0  : busy_next(1, int'(rs2));
      @(posedge clk);
      model_edge();
      #1;
      check("b_rdata1", b_rd1, e1);
      check("b_rdata2", b_rd2, e2);
      check("b_busy1",  64'(b_b1), 64'(eb1));
      check("b_busy2",  64'(b_b2), 64'(eb2));
   endtask

   task automatic idle();
      we0 = 1'b0; wa0 = '0; wd0 = '0;
      we1 = 1'b0; wa1 = '0; wd1 = '0;
      alloc_en = 1'b0; alloc_rd = '0;
   endtask

   initial begin
      reset = 1'b1; rs1 = 5'd3; rs2 = 5'd0;
      idle();
      repeat (2) @(posedge clk);
      model_edge();
      #1;
      reset = 1'b0;
      #1;
      check("rst_a_rd1", 64'(a_rd1), 64'd0);
      check("rst_a_bz1", 64'(a_b1), 64'd0);
      check("rst_b_rd1", b_rd1, 64'd0);

      // x1..x5 = 1..5 via port 0, then read pairs
      for (int i = 1; i <= 5; i++) begin
         we0 = 1'b1; wa0 = 5'(i); wd0 = 64'(i);
         cycle();
      end
      idle();
      rs1 = 5'd1; rs2 = 5'd2;
      #1;
      check("x1", 64'(a_rd1), 64'd1);
      check("x2", 64'(a_rd2), 64'd2);
      cycle();
      rs1 = 5'd4; rs2 = 5'd5;
      cycle();
      check("b_x4", b_rd1, 64'd4);
      check("b_x5", b_rd2, 64'd5);
      rs1 = 5'd0;
      cycle();

      // dual write to x3, port 1 wins
      we0 = 1'b1; wa0 = 5'd3; wd0 = 64'hA;
      we1 = 1'b1; wa1 = 5'd3; wd1 = 64'hB;
      rs1 = 5'd3;
      #1;
      check("bypass_x3", 64'(a_rd1), 64'hB);
      cycle();
      check("b_x3", b_rd1, 64'hB);
      idle();
      cycle();

      // alloc x7, then write it
      alloc_en = 1'b1; alloc_rd = 5'd7; rs1 = 5'd7;
      cycle();
      idle();
      #1;
      check("alloc_busy7", 64'(a_b1), 64'd1);
      we0 = 1'b1; wa0 = 5'd7; wd0 = 64'h55;
      #1;
      check("wr_clr_busy7", 64'(a_b1), 64'd0);
      check("wr_bypass7", 64'(a_rd1), 64'h55);
      cycle();
      idle();

      // alloc and write x9 together
      alloc_en = 1'b1; alloc_rd = 5'd9; we1 = 1'b1; wa1 = 5'd9; wd1 = 64'h99; rs1 = 5'd9;
      cycle();
      check("b_x9_busy", 64'(b_b1), 64'd1);
      idle();
      #1;
      check("a_x9", 64'(a_rd1), 64'h99);
      check("a_x9_busy", 64'(a_b1), 64'd1);
      cycle();

      // x0 write/alloc ignored, then reset mid-stream with x5 busy
      we0 = 1'b1; wa0 = 5'd0; wd0 = 64'hFFFF; alloc_en = 1'b1; alloc_rd = 5'd0;
      rs1 = 5'd0; rs2 = 5'd0;
      cycle();
      idle();
      #1;
      check("x0_rd", 64'(a_rd1), 64'd0);
      check("x0_busy", 64'(a_b1), 64'd0);
      alloc_en = 1'b1; alloc_rd = 5'd5;
      cycle();
      idle();
      rs1 = 5'd5;
      #1;
      check("x5_busy", 64'(a_b1), 64'd1);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      #1;
      check("rst_x5_rd", 64'(a_rd1), 64'd0);
      check("rst_x5_busy", 64'(a_b1), 64'd0);

      // 64-bit value through registered instance, then out-of-range read
      we0 = 1'b1; wa0 = 5'd15; wd0 = 64'h1_0000_0000; rs1 = 5'd15;
      cycle();
      check("b_x15", b_rd1, 64'h1_0000_0000);
      idle();
      rs1 = 5'd20;
      cycle();
      check("b_oob", b_rd1, 64'd0);

      // randomized traffic, addresses biased to cover the 16..20 out-of-range window
      for (int n = 0; n < 400; n++) begin
         reset    = ($urandom_range(0, 39) == 0);
         we0      = 1'($urandom_range(0, 1));
         we1      = 1'($urandom_range(0, 1));
         alloc_en = 1'($urandom_range(0, 1));
         wa0      = 5'($urandom_range(0, 20));
         wa1      = 5'($urandom_range(0, 20));
         alloc_rd = 5'($urandom_range(0, 20));
         rs1      = 5'($urandom_range(0, 20));
         rs2      = ($urandom_range(0, 2) == 0) ? wa0 : 5'($urandom_range(0, 31));
         wd0      = {$urandom, $urandom};
         wd1      = {$urandom, $urandom};
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
